// File: rtl/la_iopwr_seq_pkg.sv
// Shared types and constants for the io-ring power-up sequencer.
package la_iopwr_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        CWAIT = 3'd1,
        RAMP  = 3'd2,
        ON    = 3'd3,
        FAULT = 3'd4
    } state_e;

endpackage

// File: rtl/la_iopwr_debounce.sv
// Supply-good conditioning: a multi-flop synchronizer followed by a
// saturating qualification counter. Loss is reported straight from the
// synchronizer output so teardown is not delayed by the debounce window.
module la_iopwr_debounce #(
    parameter int SYNCW    = 2,
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic nreset,
    input  logic in,
    output logic stable,
    output logic lost
);

    localparam int               CNT_W   = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

    logic [SYNCW-1:0] r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             w_synced;

    assign w_synced = r_sync[SYNCW-1];

    // Shift the asynchronous supply indication into the clk domain.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNCW-2:0], in};
        end
    end

    // Count consecutive synced-high cycles, holding at the qualification value.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt <= '0;
        end else if (!w_synced) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign stable = (r_cnt == CNT_MAX);
    assign lost   = ~w_synced;

endmodule

// File: rtl/la_iopwr_seq.sv
// Io-ring power-up sequencer: waits for the io then the core supply to be
// stable, enables pad groups one at a time, releases core reset last, and
// tears everything down in one edge when a supply drops while powered.
//
//   state | meaning
//   IDLE  | waiting for io supply to be stable
//   CWAIT | io stable, waiting for core supply
//   RAMP  | enabling pad groups, one per step
//   ON    | all groups enabled, core reset released
//   FAULT | supply lost while powered; waits for fault_clr
module la_iopwr_seq
    import la_iopwr_seq_pkg::*;
#(
    parameter int NGROUP   = 4,
    parameter int DEBOUNCE = 16,
    parameter int STEP     = 8,
    parameter int SYNCW    = 2
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               vddio_ok,
    input  logic               vdd_ok,
    input  logic               fault_clr,
    output logic [NGROUP-1:0]  ioring_en,
    output logic               core_nreset,
    output logic               pwr_good,
    output logic               fault,
    output logic [STATE_W-1:0] state
);

    localparam int              STEP_W    = $clog2(STEP + 1);
    localparam int              GRP_W     = $clog2(NGROUP + 1);
    localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP - 1);
    localparam logic [GRP_W-1:0]  GRP_LAST  = GRP_W'(NGROUP);

    logic w_io_stable;
    logic w_io_lost;
    logic w_vdd_stable;
    logic w_vdd_lost;
    logic w_go_fault;

    state_e            r_state;
    logic [NGROUP-1:0] r_ioring_en;
    logic              r_core_nreset;
    logic              r_pwr_good;
    logic              r_fault;
    logic [STEP_W-1:0] r_step;
    logic [GRP_W-1:0]  r_grp;

    la_iopwr_debounce #(
        .SYNCW    (SYNCW),
        .DEBOUNCE (DEBOUNCE)
    ) u_db_io (
        .clk    (clk),
        .nreset (nreset),
        .in     (vddio_ok),
        .stable (w_io_stable),
        .lost   (w_io_lost)
    );

    la_iopwr_debounce #(
        .SYNCW    (SYNCW),
        .DEBOUNCE (DEBOUNCE)
    ) u_db_vdd (
        .clk    (clk),
        .nreset (nreset),
        .in     (vdd_ok),
        .stable (w_vdd_stable),
        .lost   (w_vdd_lost)
    );

    // Loss while powered (or io loss while waiting on core) beats any step advance.
    always_comb begin
        w_go_fault = 1'b0;
        if ((r_state == RAMP) || (r_state == ON)) begin
            w_go_fault = w_io_lost | w_vdd_lost;
        end else if (r_state == CWAIT) begin
            w_go_fault = w_io_lost;
        end
    end

    // Sequencer FSM; outputs are written on the same edge as the state change.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state       <= IDLE;
            r_ioring_en   <= '0;
            r_core_nreset <= 1'b0;
            r_pwr_good    <= 1'b0;
            r_fault       <= 1'b0;
            r_step        <= '0;
            r_grp         <= '0;
        end else if (w_go_fault) begin
            r_state       <= FAULT;
            r_ioring_en   <= '0;
            r_core_nreset <= 1'b0;
            r_pwr_good    <= 1'b0;
            r_fault       <= 1'b1;
            r_step        <= '0;
            r_grp         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_io_stable) begin
                        r_state <= CWAIT;
                    end
                end
                CWAIT: begin
                    if (w_vdd_stable) begin
                        r_state     <= RAMP;
                        r_ioring_en <= NGROUP'(1);
                        r_grp       <= GRP_W'(1);
                        r_step      <= STEP_LOAD;
                    end
                end
                RAMP: begin
                    if (r_step != '0) begin
                        r_step <= r_step - STEP_W'(1);
                    end else if (r_grp == GRP_LAST) begin
                        // Final step elapsed after the last group: release core.
                        r_state       <= ON;
                        r_core_nreset <= 1'b1;
                        r_pwr_good    <= 1'b1;
                        r_grp         <= '0;
                    end else begin
                        // Groups fill from bit 0 upward, so a shift-in of 1 enables the next one.
                        r_ioring_en <= (r_ioring_en << 1) | NGROUP'(1);
                        r_grp       <= r_grp + GRP_W'(1);
                        r_step      <= STEP_LOAD;
                    end
                end
                ON: begin
                    r_state <= ON;
                end
                FAULT: begin
                    if (fault_clr) begin
                        r_state <= IDLE;
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_ioring_en   <= '0;
                    r_core_nreset <= 1'b0;
                    r_pwr_good    <= 1'b0;
                    r_fault       <= 1'b0;
                    r_step        <= '0;
                    r_grp         <= '0;
                end
            endcase
        end
    end

    assign ioring_en   = r_ioring_en;
    assign core_nreset = r_core_nreset;
    assign pwr_good    = r_pwr_good;
    assign fault       = r_fault;
    assign state       = r_state;

endmodule
